// File: rtl/trace_capture_pkg.sv
// Shared types and default sizes for the trace capture block.
//  trace_state_t : controller state, also exported on state_o as status.
//  TRACE_*       : default channel count, channel width and frame depth.
package trace_capture_pkg;

   typedef enum logic [2:0] {
      TR_IDLE  = 3'd0,
      TR_ARMED = 3'd1,
      TR_POST  = 3'd2,
      TR_READ  = 3'd3
   } trace_state_t;

   localparam int TRACE_NUM_CH   = 4;
   localparam int TRACE_CH_WIDTH = 32;
   localparam int TRACE_DEPTH    = 64;

endpackage

// File: rtl/trace_capture_ram.sv
// Simple dual-port sample store: one write port, one registered read port.
// The array has no reset so it maps onto block RAM.
//  clk   : clock
//  we    : write enable;  waddr/wdata : write address/data
//  re    : read enable;   raddr       : read address
//  rdata : read data, valid the cycle after re, held until the next re
module trace_ram #(
   parameter  int DEPTH = 64,
   parameter  int SW    = 128,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [SW-1:0] wdata,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output logic [SW-1:0] rdata
);

   logic [SW-1:0] mem [DEPTH];

   // write port
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // registered read port
   always_ff @(posedge clk) begin
      if (re) begin
         rdata <= mem[raddr];
      end
   end

endmodule

// File: rtl/trace_capture.sv
// On-chip trace capture: samples NUM_CH probe channels into a circular buffer,
// triggers on a masked match of one channel (or force_trig), keeps a pre-trigger
// window of pre_trig samples and streams the frame out oldest-first.
//  clk, reset_n          : clock, asynchronous active-low reset
//  probe_i, sample_en    : probe word (channel k at [k*CH_WIDTH +: CH_WIDTH]) and strobe
//  arm, abort            : start a capture (from IDLE only) / drop back to IDLE
//  force_trig            : trigger immediately while armed
//  trig_ch/mask/value    : channel select and masked compare for the trigger
//  pre_trig              : samples kept before the trigger, latched at arm
//  rd_data/valid/last    : readout stream, rd_ready from the sink
//  state_o               : current trace_state_t
module trace_capture
   import trace_capture_pkg::*;
#(
   parameter  int NUM_CH   = TRACE_NUM_CH,
   parameter  int CH_WIDTH = TRACE_CH_WIDTH,
   parameter  int DEPTH    = TRACE_DEPTH,
   localparam int SW       = NUM_CH * CH_WIDTH,
   localparam int AW       = $clog2(DEPTH),
   localparam int TW       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [SW-1:0]       probe_i,
   input  logic                sample_en,
   input  logic                arm,
   input  logic                abort,
   input  logic                force_trig,
   input  logic [TW-1:0]       trig_ch,
   input  logic [CH_WIDTH-1:0] trig_mask,
   input  logic [CH_WIDTH-1:0] trig_value,
   input  logic [AW-1:0]       pre_trig,
   output logic [SW-1:0]       rd_data,
   output logic                rd_valid,
   input  logic                rd_ready,
   output logic                rd_last,
   output logic [2:0]          state_o
);

   trace_state_t        state, state_next;
   logic [AW-1:0]       wr_ptr, start_ptr, pt, raddr;
   logic [AW:0]         fill, post_left, post_left_trig, iss_cnt;
   logic [CH_WIDTH-1:0] ch_sel;
   logic                ch_ok, hit, trig, wr_en, pop, issue, issue_last;
   logic [1:0]          occ;
   logic [SW-1:0]       ram_rdata, skid_data;
   logic                ram_vld, ram_last, skid_vld, skid_last;

   assign state_o = state;
   assign pop     = rd_valid & rd_ready;

   // select the trigger channel; an out-of-range trig_ch leaves ch_ok low
   always_comb begin
      ch_sel = '0;
      ch_ok  = 1'b0;
      for (int k = 0; k < NUM_CH; k++) begin
         if (trig_ch == TW'(k)) begin
            ch_sel = probe_i[k*CH_WIDTH +: CH_WIDTH];
            ch_ok  = 1'b1;
         end else begin
            ch_sel = ch_sel;
            ch_ok  = ch_ok;
         end
      end
   end

   assign hit = ch_ok & (((ch_sel ^ trig_value) & trig_mask) == '0);

   // next state, write enable and trigger decode
   always_comb begin
      state_next = state;
      wr_en      = 1'b0;
      trig       = 1'b0;
      // trigger sample (if any) counts as the first post sample
      post_left_trig = (AW+1)'(DEPTH) - {1'b0, pt} - {{AW{1'b0}}, sample_en};
      if (abort) begin
         state_next = TR_IDLE;
      end else begin
         case (state)
            TR_IDLE: begin
               if (arm) state_next = TR_ARMED;
               else     state_next = TR_IDLE;
            end
            TR_ARMED: begin
               wr_en = sample_en;
               // fill is the count before this cycle's write
               trig  = force_trig | (sample_en & (fill >= {1'b0, pt}) & hit);
               if (trig) begin
                  if (post_left_trig == '0) state_next = TR_READ;
                  else                      state_next = TR_POST;
               end else begin
                  state_next = TR_ARMED;
               end
            end
            TR_POST: begin
               wr_en = sample_en;
               if (sample_en && (post_left == (AW+1)'(1))) state_next = TR_READ;
               else                                        state_next = TR_POST;
            end
            TR_READ: begin
               if (pop && rd_last) state_next = TR_IDLE;
               else                state_next = TR_READ;
            end
            default: state_next = TR_IDLE;
         endcase
      end
   end

   // state register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= TR_IDLE;
      else          state <= state_next;
   end

   // capture-side pointers and counters
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr    <= '0;
         fill      <= '0;
         pt        <= '0;
         start_ptr <= '0;
         post_left <= '0;
      end else begin
         case (state)
            TR_IDLE: begin
               if (arm && !abort) begin
                  wr_ptr <= '0;
                  fill   <= '0;
                  pt     <= pre_trig;
               end
            end
            TR_ARMED, TR_POST: begin
               if (wr_en) begin
                  wr_ptr <= wr_ptr + {{(AW-1){1'b0}}, 1'b1};
                  if (fill != (AW+1)'(DEPTH)) fill <= fill + {{AW{1'b0}}, 1'b1};
               end
               if (trig) begin
                  start_ptr <= wr_ptr - pt;
                  post_left <= post_left_trig;
               end else if ((state == TR_POST) && sample_en) begin
                  post_left <= post_left - {{AW{1'b0}}, 1'b1};
               end
            end
            default: begin
            end
         endcase
      end
   end

   // read issue: only fetch when the output and skid registers can absorb it
   always_comb begin
      occ        = 2'(rd_valid & ~pop) + 2'(skid_vld) + 2'(ram_vld);
      raddr      = start_ptr + iss_cnt[AW-1:0];
      issue_last = (iss_cnt == (AW+1)'(DEPTH - 1));
      if ((state == TR_READ) && !abort && !iss_cnt[AW] && (occ < 2'd2)) begin
         issue = 1'b1;
      end else begin
         issue = 1'b0;
      end
   end

   trace_ram #(.DEPTH(DEPTH), .SW(SW)) u_ram (
      .clk   (clk),
      .we    (wr_en),
      .waddr (wr_ptr),
      .wdata (probe_i),
      .re    (issue),
      .raddr (raddr),
      .rdata (ram_rdata)
   );

   // readout pipeline: RAM data -> optional skid -> output register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         iss_cnt   <= '0;
         ram_vld   <= 1'b0;
         ram_last  <= 1'b0;
         skid_vld  <= 1'b0;
         skid_last <= 1'b0;
         skid_data <= '0;
         rd_valid  <= 1'b0;
         rd_last   <= 1'b0;
         rd_data   <= '0;
      end else if (abort || (state != TR_READ)) begin
         iss_cnt  <= '0;
         ram_vld  <= 1'b0;
         skid_vld <= 1'b0;
         rd_valid <= 1'b0;
         rd_last  <= 1'b0;
      end else begin
         iss_cnt  <= iss_cnt + {{AW{1'b0}}, issue};
         ram_vld  <= issue;
         ram_last <= issue_last;
         if (!rd_valid || pop) begin
            if (skid_vld) begin
               rd_data   <= skid_data;
               rd_last   <= skid_last;
               rd_valid  <= 1'b1;
               skid_vld  <= ram_vld;
               skid_data <= ram_rdata;
               skid_last <= ram_last;
            end else if (ram_vld) begin
               rd_data  <= ram_rdata;
               rd_last  <= ram_last;
               rd_valid <= 1'b1;
            end else begin
               rd_valid <= 1'b0;
               rd_last  <= 1'b0;
            end
         end else if (ram_vld) begin
            skid_vld  <= 1'b1;
            skid_data <= ram_rdata;
            skid_last <= ram_last;
         end
      end
   end

endmodule

// File: tb/tb_trace_capture.sv
// Directed bench for trace_capture (NUM_CH=4, CH_WIDTH=8, DEPTH=16).
// Probe channel 0 carries a sample counter n that restarts at 0 on the first
// armed cycle; the other channels are fixed functions of n. Expected frames are
// queued when a capture is set up and popped on each readout handshake.
module tb_trace_capture;
   import trace_capture_pkg::*;

   localparam int NCH = 4;
   localparam int CW  = 8;
   localparam int DP  = 16;
   localparam int SW  = NCH * CW;

   logic          clk, reset_n;
   logic [SW-1:0] probe_i;
   logic          sample_en, arm, abort, force_trig;
   logic [1:0]    trig_ch;
   logic [CW-1:0] trig_mask, trig_value;
   logic [3:0]    pre_trig;
   logic [SW-1:0] rd_data;
   logic          rd_valid, rd_ready, rd_last;
   logic [2:0]    state_o;

   int vectors = 0;
   int errs    = 0;
   int n       = 0;
   logic [SW-1:0] sb [$];

   trace_capture #(.NUM_CH(NCH), .CH_WIDTH(CW), .DEPTH(DP)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .probe_i    (probe_i),
      .sample_en  (sample_en),
      .arm        (arm),
      .abort      (abort),
      .force_trig (force_trig),
      .trig_ch    (trig_ch),
      .trig_mask  (trig_mask),
      .trig_value (trig_value),
      .pre_trig   (pre_trig),
      .rd_data    (rd_data),
      .rd_valid   (rd_valid),
      .rd_ready   (rd_ready),
      .rd_last    (rd_last),
      .state_o    (state_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [SW-1:0] mk(input int k);
      logic [7:0] b;
      b = k[7:0];
      return {8'hA5, ~b, b + 8'h40, b};
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // one clock: present sample n, let the edge happen, return at the falling edge
   task automatic step();
      probe_i = mk(n);
      @(posedge clk);
      n = n + 1;
      @(negedge clk);
   endtask

   task automatic do_arm(input int pt);
      pre_trig = 4'(pt);
      arm = 1'b1;
      step();
      arm = 1'b0;
      n = 0;
      check("armed", 64'(state_o), 64'(TR_ARMED));
   endtask

   task automatic push_frame(input int first);
      for (int i = 0; i < DP; i++) sb.push_back(mk(first + i));
   endtask

   task automatic wait_state(input string tag, input logic [2:0] target, input int budget);
      int k;
      k = 0;
      while (state_o !== target && k < budget) begin
         step();
         k++;
      end
      check(tag, 64'(state_o), 64'(target));
   endtask

   // mode 0: always ready, 1: toggle, 2: random; abort_at < 0 means no abort
   task automatic read_frame(input int mode, input int abort_at);
      int cyc, words;
      logic stalled, done;
      logic [SW-1:0] held, exp;
      cyc = 0; words = 0; stalled = 1'b0; done = 1'b0; held = '0;
      while (!done && cyc < 200) begin
         if (cyc < 2)  check("latency_low", 64'(rd_valid), 64'd0);
         if (cyc == 2) check("latency_rise", 64'(rd_valid), 64'd1);
         if (stalled) begin
            check("hold_valid", 64'(rd_valid), 64'd1);
            check("hold_data", 64'(rd_data), 64'(held));
         end
         case (mode)
            0:       rd_ready = 1'b1;
            1:       rd_ready = (cyc % 2 == 0);
            default: rd_ready = 1'($urandom_range(1, 0));
         endcase
         if (abort_at >= 0 && words == abort_at && rd_valid) begin
            abort = 1'b1;
            rd_ready = 1'b1;
            step();
            abort = 1'b0;
            rd_ready = 1'b0;
            check("abort_state", 64'(state_o), 64'(TR_IDLE));
            check("abort_valid", 64'(rd_valid), 64'd0);
            check("abort_last", 64'(rd_last), 64'd0);
            sb.delete();
            done = 1'b1;
         end else begin
            if (rd_valid && rd_ready) begin
               if (sb.size() == 0) begin
                  check("sb_empty", 64'(sb.size()), 64'd1);
               end else begin
                  exp = sb.pop_front();
                  check("rd_data", 64'(rd_data), 64'(exp));
                  check("rd_last", 64'(rd_last), 64'(words == DP - 1));
               end
               words++;
            end
            stalled = rd_valid && !rd_ready;
            held = rd_data;
            step();
            cyc++;
            if (words == DP) begin
               done = 1'b1;
               rd_ready = 1'b0;
               check("end_state", 64'(state_o), 64'(TR_IDLE));
               check("end_valid", 64'(rd_valid), 64'd0);
            end
         end
      end
      if (!done) check("read_timeout", 64'(words), 64'(DP));
   endtask

   initial begin
      reset_n = 1'b0; probe_i = '0; sample_en = 1'b1; arm = 1'b0; abort = 1'b0;
      force_trig = 1'b0; trig_ch = 2'd0; trig_mask = 8'hFF; trig_value = 8'h0A;
      pre_trig = 4'd0; rd_ready = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_state", 64'(state_o), 64'(TR_IDLE));
      check("rst_valid", 64'(rd_valid), 64'd0);
      check("rst_last", 64'(rd_last), 64'd0);
      check("rst_data", 64'(rd_data), 64'd0);
      reset_n = 1'b1;
      step();

      // 1: reset in the middle of POST
      trig_ch = 2'd0; trig_mask = 8'hFF; trig_value = 8'h0A;
      do_arm(4);
      wait_state("t1_post", TR_POST, 40);
      step();
      step();
      reset_n = 1'b0;
      #1;
      check("t1_async_state", 64'(state_o), 64'(TR_IDLE));
      check("t1_async_valid", 64'(rd_valid), 64'd0);
      @(negedge clk);
      reset_n = 1'b1;
      step();

      // 2: PT=4, match 0x0A, frame 0x06..0x15 (also proves re-arm after reset)
      do_arm(4);
      push_frame(6);
      wait_state("t2_read", TR_READ, 60);
      read_frame(0, -1);

      // 3 + 4: match 0x02 on low nibble before the window is full, toggled ready
      trig_value = 8'h02; trig_mask = 8'h0F;
      do_arm(4);
      push_frame(14);
      repeat (3) step();
      check("t3_no_early_trig", 64'(state_o), 64'(TR_ARMED));
      wait_state("t3_read", TR_READ, 60);
      read_frame(1, -1);

      // 5: non-matching channel 3, forced trigger at n=0x20, PT=0, random stalls
      trig_ch = 2'd3; trig_value = 8'h5A; trig_mask = 8'hFF;
      do_arm(0);
      push_frame(32);
      while (n != 32) step();
      check("t5_no_match", 64'(state_o), 64'(TR_ARMED));
      force_trig = 1'b1;
      step();
      force_trig = 1'b0;
      check("t5_forced", 64'(state_o), 64'(TR_POST));
      wait_state("t5_read", TR_READ, 60);
      read_frame(2, -1);

      // PT=DEPTH-1: the trigger sample completes the frame, straight to READ
      trig_ch = 2'd0; trig_value = 8'h14; trig_mask = 8'hFF;
      do_arm(15);
      push_frame(5);
      while (n != 20) step();
      check("t7_pre", 64'(state_o), 64'(TR_ARMED));
      step();
      check("t7_direct_read", 64'(state_o), 64'(TR_READ));
      read_frame(0, -1);

      // 6: arm ignored in POST, abort with handshake on word 7
      trig_value = 8'h0A;
      do_arm(4);
      push_frame(6);
      wait_state("t6_post", TR_POST, 40);
      arm = 1'b1;
      step();
      arm = 1'b0;
      check("t6_arm_ignored", 64'(state_o), 64'(TR_POST));
      wait_state("t6_read", TR_READ, 60);
      read_frame(0, 7);
      step();
      check("t6_idle_after", 64'(state_o), 64'(TR_IDLE));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end

endmodule
